mul_div_unit: RTL
=================

# mul_div_unit

Iterative 32-bit multiply/divide unit for the multi-cycle CPU execute stage. It sits beside the ALU and takes the same register operands, In1 (rs) and In2 (rt). It computes MULT/MULTU/DIV/DIVU over several cycles into architectural HI/LO registers, which the writeback mux reads for MFHI/MFLO. The controller FSM holds the execute state while `busy` is high.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width; only 32 is supported.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin an operation; sampled only in IDLE.
- Op  input  2  0=MULT (signed), 1=MULTU, 2=DIV (signed), 3=DIVU.
- In1  input  32  multiplicand or dividend (rs).
- In2  input  32  multiplier or divisor (rt).
- HiWrite  input  1  MTHI: Hi <= WData; honoured only in IDLE.
- LoWrite  input  1  MTLO: Lo <= WData; honoured only in IDLE.
- WData  input  32  data for MTHI/MTLO.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; Hi/Lo hold the new result during this cycle.
- Hi  output  32  HI register (product high word or remainder).
- Lo  output  32  LO register (product low word or quotient).

## Operation
- States: IDLE, RUN, FIX.
- IDLE, start=1:
  - latch Op and the operand magnitudes; for signed ops use the two's-complement absolute value (unsigned view, so |-2^31| = 2^31).
  - latch the result sign: MULT → In1[31]^In2[31]; DIV → quotient sign In1[31]^In2[31], remainder sign In1[31].
  - clear the 6-bit iteration counter and the 64-bit accumulator; go to RUN.
- RUN, multiply: one shift-add step per cycle, LSB-first over the multiplier.
- RUN, divide: one restoring step per cycle.
  - shift {rem, quo} left by 1;
  - trial-subtract the divisor from rem; if non-negative, keep the difference and set the quotient bit.
- RUN lasts exactly 32 cycles; after the 32nd step go to FIX.
- FIX, multiply: {Hi,Lo} <= product, negated as 64 bits if the sign is set.
- FIX, divide: Lo <= quotient, Hi <= remainder, each negated if its sign is set.
- FIX, divide by zero (In2 == 0): Lo <= 32'hFFFFFFFF and Hi <= original In1, regardless of signedness.
- After FIX: pulse done and return to IDLE.
- Signed overflow (-2^31 / -1) falls out of the arithmetic: Lo = 32'h80000000, Hi = 0.
- Hi/Lo change only in FIX or via HiWrite/LoWrite in IDLE; they hold during RUN.
- start while busy: ignored; no queuing.
- start and HiWrite/LoWrite in the same IDLE cycle: start wins, the write is dropped.
- HiWrite/LoWrite while busy: ignored.
- Op and operand changes after the start edge: no effect (values are latched).

## Timing
- Reset (async, immediate): state=IDLE; busy=0, done=0, Hi=0, Lo=0; counter and accumulator cleared.
- Reset mid-operation aborts it; no done pulse is produced.
- Edge E0 samples start=1; busy rises after E0.
- Edges E1..E32: RUN iterations.
- Edge E33: FIX writes Hi/Lo, sets done=1, clears busy.
- Cycle after E33: done=1, busy=0, new Hi/Lo visible.
- Edge E34: done returns to 0.
- Total latency: 33 cycles of busy; result readable 34 cycles after the start edge.
- A new start is accepted on E34, the cycle done is high, since the state is already IDLE.
- A start accepted on E34 drops done as normal and raises busy.
- busy and done are registered outputs; Hi and Lo are registered.
- MTHI/MTLO written in IDLE are visible the cycle after the edge.

## Test plan
- Reset: assert reset mid-RUN of MULTU 7*9 → busy=0, done=0, Hi=Lo=0 immediately; no done pulse follows.
- MULT: In1=-3 (32'hFFFFFFFD), In2=5 → done exactly 34 cycles after the start edge.
  - Hi=32'hFFFFFFFF, Lo=32'hFFFFFFF1.
  - busy high for exactly 33 cycles.
- MULTU: 32'hFFFFFFFF * 32'hFFFFFFFF → Hi=32'hFFFFFFFE, Lo=32'h00000001.
- DIV: In1=-7, In2=2 → Lo=32'hFFFFFFFD (-3), Hi=32'hFFFFFFFF (-1).
- DIVU: 100/7 → Lo=14, Hi=2.
- DIV boundary cases:
  - 32'h80000000 / -1 → Lo=32'h80000000, Hi=0.
  - DIVU 5/0 → Lo=32'hFFFFFFFF, Hi=5; latency still 34.
- Handshake:
  - start pulsed again during RUN → ignored, single done pulse.
  - HiWrite during RUN → Hi unchanged.
  - HiWrite=1, WData=32'h12345678 in IDLE → Hi=32'h12345678 next cycle.
  - start asserted on the done cycle → accepted, busy stays high, second done 34 cycles later.

Source files
------------

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers
// One shift-add or restoring-divide step per cycle, then a sign-fix cycle.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic             HiWrite,
    input  logic             LoWrite,
    input  logic [WIDTH-1:0] WData,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state;
    state_t             next_state;
    logic [1:0]         op_q;
    logic [5:0]         cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   orig_in1;
    logic               q_neg;
    logic               r_neg;

    logic               op_signed;
    logic [WIDTH-1:0]   in1_abs;
    logic [WIDTH-1:0]   in2_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = RUN;
            RUN:  if (cnt == 6'(WIDTH - 1)) next_state = FIX;
            FIX:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Magnitudes in the unsigned view, so the most negative value maps to 2^(WIDTH-1).
    always_comb begin
        op_signed = ~Op[0];
        in1_abs   = (op_signed && In1[WIDTH-1]) ? (~In1 + 1'b1) : In1;
        in2_abs   = (op_signed && In2[WIDTH-1]) ? (~In2 + 1'b1) : In2;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
        div_sh    = {acc[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
        div_diff  = {1'b0, div_sh} - {2'b00, b_q};
        div_ge    = ~div_diff[WIDTH+1];
        div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
        prod_fix  = q_neg ? (~acc + 1'b1) : acc;
        quo_fix   = q_neg ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        rem_fix   = r_neg ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            Hi       <= '0;
            Lo       <= '0;
            op_q     <= '0;
            cnt      <= '0;
            acc      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            orig_in1 <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != IDLE);
            done  <= (state == FIX);
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q     <= Op;
                        a_q      <= in1_abs;
                        b_q      <= in2_abs;
                        orig_in1 <= In1;
                        q_neg    <= op_signed & (In1[WIDTH-1] ^ In2[WIDTH-1]);
                        r_neg    <= op_signed & In1[WIDTH-1];
                        cnt      <= '0;
                        acc      <= '0;
                    end else begin
                        if (HiWrite) Hi <= WData;
                        if (LoWrite) Lo <= WData;
                    end
                end
                RUN: begin
                    cnt <= cnt + 6'd1;
                    if (op_q[1]) begin
                        acc <= {div_rem, acc[WIDTH-2:0], div_ge};
                        a_q <= a_q << 1;
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                        b_q <= b_q >> 1;
                    end
                end
                FIX: begin
                    if (!op_q[1]) begin
                        Hi <= prod_fix[2*WIDTH-1:WIDTH];
                        Lo <= prod_fix[WIDTH-1:0];
                    end else if (b_q == '0) begin
                        Hi <= orig_in1;
                        Lo <= '1;
                    end else begin
                        Hi <= rem_fix;
                        Lo <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
